// File: rtl/sramlike_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sramlike_pkg: shared types and helpers for the SRAM-like responder. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package sramlike_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Wide enough for any practical DATA_LAT (up to 256).
    localparam int TIMER_W = 8;

    typedef struct packed {
        logic               wr;
        logic [1:0]         size;
        logic [31:0]        addr;
        logic [31:0]        wdata;
        logic [TIMER_W-1:0] timer;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << addr_lo;
            SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sramlike_req_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sramlike_req_fifo: circular request FIFO with per-entry countdown.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sramlike_req_fifo
    import sramlike_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [ENTRY_W-1:0]           push_entry_i,
    input  logic                         pop_i,
    output logic [ENTRY_W-1:0]           head_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    req_entry_t       entries_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i & (count_q != FULL_CNT);
    assign do_pop  = pop_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].timer != '0) begin
                    entries_q[i].timer <= entries_q[i].timer - TIMER_W'(1);
                end
            end
            // The push slot is free, so overriding its decrement is harmless.
            if (do_push) begin
                entries_q[wr_ptr_q] <= req_entry_t'(push_entry_i);
            end
        end
    end

    assign head_o  = entries_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/sramlike_sram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sramlike_sram_slave: SRAM-like bus responder backed by a word RAM.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sramlike_sram_slave
    import sramlike_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int ADDR_DELAY = 0,
    parameter int DATA_LAT   = 1,
    parameter int DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok
);

    localparam int WAIT_W = (ADDR_DELAY > 0) ? $clog2(ADDR_DELAY + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ADDR_DELAY);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               accept, retire;
    req_entry_t         push_entry, head;
    logic [ENTRY_W-1:0] head_bits;
    logic               fifo_empty;
    logic               unused_full;
    logic [CNT_W-1:0]   fifo_count;
    logic [ADDR_W-1:0]  word_idx;
    logic [3:0]         wstrb;
    logic               unused_bits;
    logic [31:0]        mem [0:(1<<ADDR_W)-1];

    // No full bypass: a same-cycle pop does not free a slot for a push.
    assign data_addr_ok = ~rst & data_req & (wait_q == WAIT_MAX) & (fifo_count < DEPTH_CNT);
    assign accept       = data_req & data_addr_ok;

    always_comb begin
        wait_d = wait_q;
        if (!data_req || accept) begin
            wait_d = '0;
        end else if (wait_q != WAIT_MAX) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.wr    = data_wr;
        push_entry.size  = data_size;
        push_entry.addr  = data_addr;
        push_entry.wdata = data_wdata;
        push_entry.timer = TIMER_W'(DATA_LAT - 1);
    end

    sramlike_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (accept),
        .push_entry_i (push_entry),
        .pop_i        (retire),
        .head_o       (head_bits),
        .empty_o      (fifo_empty),
        .full_o       (unused_full),
        .count_o      (fifo_count)
    );

    assign head     = req_entry_t'(head_bits);
    assign retire   = ~rst & ~fifo_empty & (head.timer == '0);
    assign word_idx = head.addr[ADDR_W+1:2];
    assign wstrb    = byte_strobe(head.size, head.addr[1:0]);

    assign data_data_ok = retire;
    assign data_rdata   = (retire && !head.wr) ? mem[word_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (retire && head.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx][8*b +: 8] <= head.wdata[8*b +: 8];
                end
            end
        end
    end

    assign unused_bits = ^{unused_full, head.addr[31:ADDR_W+2]};

endmodule
`default_nettype wire
